// File: rtl/nr_div_pkg.sv
// nr_div_pkg: shared state encoding and sizing helper for the sequential non-restoring divider.
package nr_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} nr_div_state_t;

    function automatic int nr_div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/nr_divider_seq_addsub.sv
// nr_addsub: N-bit modular add (m_i=0) or subtract (m_i=1) via b XOR m with carry-in m.
module nr_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         m_i,
    output logic [N-1:0] s_o
);

    assign s_o = a_i + (b_i ^ {N{m_i}}) + {{(N-1){1'b0}}, m_i};

endmodule

// File: rtl/nr_divider_seq.sv
// nr_divider_seq: unsigned non-restoring divider, one quotient bit per clock plus a remainder fix step,
// with valid/ready handshakes and divide-by-zero detection.
module nr_divider_seq
    import nr_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dividend,
    input  logic [W-1:0] in_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quotient,
    output logic [W-1:0] out_remainder,
    output logic         out_div_by_zero,
    output logic         busy
);

    localparam int CW = nr_div_cnt_w(W);

    nr_div_state_t state_q;
    logic [W:0]    a_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  y_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    add_a;
    logic [W:0]    a_d;
    logic          add_m;

    // RUN feeds the shifted partial remainder; FIX adds Y back to the unshifted A
    assign add_a = (state_q == RUN) ? {a_q[W-1:0], q_q[W-1]} : a_q;
    assign add_m = (state_q == RUN) ? ~a_q[W] : 1'b0;

    nr_addsub #(.N(W + 1)) u_addsub (
        .a_i(add_a),
        .b_i({1'b0, y_q}),
        .m_i(add_m),
        .s_o(a_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            a_q             <= '0;
            q_q             <= '0;
            y_q             <= '0;
            cnt_q           <= '0;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (in_divisor == '0) begin
                        state_q         <= DONE;
                        out_valid       <= 1'b1;
                        out_quotient    <= '1;
                        out_remainder   <= in_dividend;
                        out_div_by_zero <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        a_q     <= '0;
                        q_q     <= in_dividend;
                        y_q     <= in_divisor;
                        cnt_q   <= CW'(W);
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= {q_q[W-2:0], ~a_d[W]};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    state_q         <= DONE;
                    out_valid       <= 1'b1;
                    out_quotient    <= q_q;
                    out_remainder   <= a_q[W] ? a_d[W-1:0] : a_q[W-1:0];
                    out_div_by_zero <= 1'b0;
                end
                DONE: if (out_ready) begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
